// File: rtl/commit_trace_unit.sv
`default_nettype none
// ============================================================================
//  Module   : commit_trace_unit
//  Purpose  : Retirement trace producer. Packs WB register writes, MEM
//             loads/stores and halt into typed records, buffers them in a
//             multi-push FIFO and drains them over a valid/ready port.
//             Keeps saturating retired-instruction, cycle and drop counters.
//  Options  : TRACE_STAMP_EN - each entry carries the capture-time
//             cycle_count, mirrored on trc_stamp_o for the head record.
//  Revision : 1.0 - initial release
// ============================================================================
module commit_trace_unit #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_reg_write_i,
   input  logic [3:0]       wb_reg_sel_i,
   input  logic [15:0]      wb_reg_data_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [15:0]      mem_addr_i,
   input  logic [15:0]      mem_wdata_i,
   input  logic [15:0]      mem_rdata_i,
   input  logic             hlt_in_i,
   output logic             trc_valid_o,
   input  logic             trc_ready_i,
   output logic [1:0]       trc_type_o,
   output logic [15:0]      trc_addr_o,
   output logic [15:0]      trc_data_o,
`ifdef TRACE_STAMP_EN
   output logic [CNT_W-1:0] trc_stamp_o,
`endif
   output logic             overflow_o,
   output logic [CNT_W-1:0] drop_count_o,
   output logic [CNT_W-1:0] inst_count_o,
   output logic [CNT_W-1:0] cycle_count_o,
   output logic             done_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_FW = $clog2(DEPTH + 1);
   localparam int SUM_W  = CNT_W + 2;

   localparam logic [1:0] TYPE_REG   = 2'b00;
   localparam logic [1:0] TYPE_LOAD  = 2'b01;
   localparam logic [1:0] TYPE_STORE = 2'b10;
   localparam logic [1:0] TYPE_HALT  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Record storage (no reset: validity is tracked by count_q)
   logic [1:0]        type_mem_q [DEPTH];
   logic [15:0]       addr_mem_q [DEPTH];
   logic [15:0]       data_mem_q [DEPTH];
`ifdef TRACE_STAMP_EN
   logic [CNT_W-1:0]  stamp_mem_q [DEPTH];
`endif

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_FW-1:0] count_q, count_d;
   logic [CNT_W-1:0]  inst_q, inst_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              overflow_q, overflow_d;

   // Per-cycle candidate records, compacted into slots 0..n_cand-1
   logic [1:0]        cand_type [3];
   logic [15:0]       cand_addr [3];
   logic [15:0]       cand_data [3];
   logic [1:0]        n_cand;
   logic [1:0]        n_push;
   logic [1:0]        n_drop;
   logic [CNT_FW-1:0] free_slots;
   logic [SUM_W-1:0]  inst_sum;
   logic [SUM_W-1:0]  drop_sum;
   logic              pop;

   // Candidate building, push/drop split, counters and next state
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      cycle_d    = cycle_q;
      drop_d     = drop_q;
      overflow_d = overflow_q;
      cand_type  = '{default: '0};
      cand_addr  = '{default: '0};
      cand_data  = '{default: '0};
      n_cand     = 2'd0;
      n_push     = 2'd0;
      n_drop     = 2'd0;
      inst_sum   = '0;
      drop_sum   = '0;
      pop        = (count_q != '0) && trc_ready_i;
      // Space is judged at start of cycle; a same-cycle pop does not help
      free_slots = CNT_FW'(DEPTH) - count_q;

      if (state_q == ST_RUN) begin
         inst_sum = {2'b00, inst_q} + SUM_W'(wb_reg_write_i)
                  + SUM_W'(mem_write_i) + SUM_W'(hlt_in_i);
         inst_d   = (inst_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                         : inst_sum[CNT_W-1:0];
         cycle_d  = (&cycle_q) ? cycle_q : cycle_q + 1'b1;

         if (wb_reg_write_i) begin
            cand_type[n_cand] = TYPE_REG;
            cand_addr[n_cand] = {12'b0, wb_reg_sel_i};
            cand_data[n_cand] = wb_reg_data_i;
            n_cand            = n_cand + 2'd1;
         end
         if (mem_read_i) begin
            cand_type[n_cand] = TYPE_LOAD;
            cand_addr[n_cand] = mem_addr_i;
            cand_data[n_cand] = mem_rdata_i;
            n_cand            = n_cand + 2'd1;
         end else if (mem_write_i) begin
            cand_type[n_cand] = TYPE_STORE;
            cand_addr[n_cand] = mem_addr_i;
            cand_data[n_cand] = mem_wdata_i;
            n_cand            = n_cand + 2'd1;
         end
         if (hlt_in_i) begin
            // HALT reports the counters as updated in this same cycle
            cand_type[n_cand] = TYPE_HALT;
            cand_addr[n_cand] = 16'(cycle_d);
            cand_data[n_cand] = 16'(inst_d);
            n_cand            = n_cand + 2'd1;
            state_d           = ST_DRAIN;
         end

         if ({{(CNT_FW-2){1'b0}}, n_cand} <= free_slots) begin
            n_push = n_cand;
         end else begin
            n_push = free_slots[1:0];
         end
         n_drop = n_cand - n_push;

         if (n_drop != 2'd0) begin
            overflow_d = 1'b1;
            drop_sum   = {2'b00, drop_q} + SUM_W'(n_drop);
            drop_d     = (drop_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                              : drop_sum[CNT_W-1:0];
         end
      end else if (state_q == ST_DRAIN) begin
         // Finished once the FIFO is (or is becoming) empty
         if ((count_q == '0) || (pop && (count_q == CNT_FW'(1)))) begin
            state_d = ST_DONE;
         end
      end

      count_d = count_q + CNT_FW'(n_push) - CNT_FW'(pop);
   end

   // Control state, pointers and counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inst_q     <= '0;
         cycle_q    <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_q + PTR_W'(n_push);
         rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
         count_q    <= count_d;
         inst_q     <= inst_d;
         cycle_q    <= cycle_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
      end
   end

   // Record storage writes: up to three consecutive slots per cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < n_push) begin
            type_mem_q[wr_ptr_q + PTR_W'(i)] <= cand_type[i];
            addr_mem_q[wr_ptr_q + PTR_W'(i)] <= cand_addr[i];
            data_mem_q[wr_ptr_q + PTR_W'(i)] <= cand_data[i];
`ifdef TRACE_STAMP_EN
            stamp_mem_q[wr_ptr_q + PTR_W'(i)] <= cycle_d;
`endif
         end
      end
   end

   assign trc_valid_o   = (count_q != '0);
   assign trc_type_o    = trc_valid_o ? type_mem_q[rd_ptr_q] : 2'b00;
   assign trc_addr_o    = trc_valid_o ? addr_mem_q[rd_ptr_q] : 16'h0000;
   assign trc_data_o    = trc_valid_o ? data_mem_q[rd_ptr_q] : 16'h0000;
`ifdef TRACE_STAMP_EN
   assign trc_stamp_o   = trc_valid_o ? stamp_mem_q[rd_ptr_q] : '0;
`endif
   assign overflow_o    = overflow_q;
   assign drop_count_o  = drop_q;
   assign inst_count_o  = inst_q;
   assign cycle_count_o = cycle_q;
   assign done_o        = (state_q == ST_DONE);

endmodule
`default_nettype wire
